ka_gf2_mult_seq: RTL and testbench

Parametrised, iterative Karatsuba multiplier over GF(2)[x]. It computes the carry-less product of two WIDTH-bit polynomials. It can optionally reduce that product modulo a fixed polynomial POLY. One top-level Karatsuba split is performed, and the three half-products are evaluated sequentially on a single shared half-width carry-less multiplier, which trades throughput for area against the fully combinational KA_nbit tree. It sits between operand staging and the field-arithmetic datapath, with valid/ready handshakes on both sides.

---
 rtl/ka_gf2_mult_seq_if.sv | 23 ++
 rtl/ka_gf2_mult_seq.sv | 207 ++++++++++++++++++++
 tb/tb_ka_gf2_mult_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ka_gf2_mult_seq_if.sv
// Operand/result handshake bundle for the sequential Karatsuba GF(2)[x] multiplier.
interface ka_gf2_mult_seq_if #(
  parameter int unsigned WIDTH = 36
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 reduce;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-2:0]   y;

  modport master (
    output in_valid, a, b, reduce, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, reduce, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/ka_gf2_mult_seq.sv
// Iterative one-level Karatsuba carry-less multiplier with optional reduction mod POLY.
// The three half-products share one H x H carry-less multiplier, sequenced by the FSM.
module ka_gf2_mult_seq #(
  parameter int unsigned     WIDTH = 36,
  parameter logic [WIDTH:0]  POLY  = 37'h10_0000_0801
) (
  input  logic                clk,
  input  logic                rst_n,
  ka_gf2_mult_seq_if.slave    bus
);

  localparam int unsigned H  = (WIDTH + 1) / 2;
  localparam int unsigned PW = 2 * H - 1;
  localparam int unsigned FW = 2 * WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_M0   = 3'd1,
    S_M1   = 3'd2,
    S_M2   = 3'd3,
    S_COMB = 3'd4,
    S_RED  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  function automatic logic [PW-1:0] clmul_h(input logic [H-1:0] x, input logic [H-1:0] z);
    logic [PW-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(H); i++) begin
      if (z[i]) acc = acc ^ (PW'(x) << i);
    end
    return acc;
  endfunction

  // Bits above WIDTH-1 end up cleared, so the result is already zero-extended.
  function automatic logic [FW-1:0] reduce_poly(input logic [FW-1:0] p);
    logic [FW-1:0] acc;
    acc = p;
    for (int k = int'(FW) - 1; k >= int'(WIDTH); k--) begin
      if (acc[k]) acc = acc ^ (FW'(POLY) << (k - int'(WIDTH)));
    end
    return acc;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             w_in_ready_nxt;
  logic             w_out_valid_nxt;
  logic             w_accept;
  logic             w_xfer;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_reduce;
  logic [PW-1:0]    r_p0;
  logic [PW-1:0]    r_p1;
  logic [PW-1:0]    r_p2;
  logic [FW-1:0]    r_full;
  logic [FW-1:0]    r_y;

  logic [H-1:0]     w_a_lo;
  logic [H-1:0]     w_a_hi;
  logic [H-1:0]     w_b_lo;
  logic [H-1:0]     w_b_hi;
  logic [H-1:0]     w_mul_x;
  logic [H-1:0]     w_mul_z;
  logic [PW-1:0]    w_prod;
  logic [FW-1:0]    w_full;
  logic [FW-1:0]    w_red;

  logic             w_ld_in;
  logic             w_ld_p0;
  logic             w_ld_p1;
  logic             w_ld_p2;
  logic             w_ld_full;
  logic             w_ld_y_full;
  logic             w_ld_y_red;

  assign w_accept = r_in_ready & bus.in_valid;
  assign w_xfer   = r_out_valid & bus.out_ready;

  assign w_a_lo = r_a[H-1:0];
  assign w_a_hi = H'(r_a[WIDTH-1:H]);
  assign w_b_lo = r_b[H-1:0];
  assign w_b_hi = H'(r_b[WIDTH-1:H]);

  // Operand mux in front of the single shared half-width multiplier.
  always_comb begin
    w_mul_x = '0;
    w_mul_z = '0;
    case (r_state)
      S_M0: begin
        w_mul_x = w_a_lo;
        w_mul_z = w_b_lo;
      end
      S_M1: begin
        w_mul_x = w_a_hi;
        w_mul_z = w_b_hi;
      end
      S_M2: begin
        w_mul_x = w_a_lo ^ w_a_hi;
        w_mul_z = w_b_lo ^ w_b_hi;
      end
      default: begin
        w_mul_x = '0;
        w_mul_z = '0;
      end
    endcase
  end

  assign w_prod = clmul_h(w_mul_x, w_mul_z);
  assign w_full = FW'(r_p0) ^ (FW'(r_p0 ^ r_p1 ^ r_p2) << H) ^ (FW'(r_p1) << (2 * H));
  assign w_red  = reduce_poly(r_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_M0;
      S_M0:    w_state_nxt = S_M1;
      S_M1:    w_state_nxt = S_M2;
      S_M2:    w_state_nxt = S_COMB;
      S_COMB:  w_state_nxt = r_reduce ? S_RED : S_DONE;
      S_RED:   w_state_nxt = S_DONE;
      S_DONE:  if (w_xfer) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // out_valid rises one cycle into DONE, after y has already settled.
  always_comb begin
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_ld_in         = 1'b0;
    w_ld_p0         = 1'b0;
    w_ld_p1         = 1'b0;
    w_ld_p2         = 1'b0;
    w_ld_full       = 1'b0;
    w_ld_y_full     = 1'b0;
    w_ld_y_red      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready_nxt = ~w_accept;
        w_ld_in        = w_accept;
      end
      S_M0:   w_ld_p0 = 1'b1;
      S_M1:   w_ld_p1 = 1'b1;
      S_M2:   w_ld_p2 = 1'b1;
      S_COMB: begin
        w_ld_full   = 1'b1;
        w_ld_y_full = ~r_reduce;
      end
      S_RED:  w_ld_y_red = 1'b1;
      S_DONE: begin
        w_out_valid_nxt = ~w_xfer;
        w_in_ready_nxt  = w_xfer;
      end
      default: begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_reduce <= 1'b0;
      r_p0     <= '0;
      r_p1     <= '0;
      r_p2     <= '0;
      r_full   <= '0;
      r_y      <= '0;
    end else begin
      if (w_ld_in) begin
        r_a      <= bus.a;
        r_b      <= bus.b;
        r_reduce <= bus.reduce;
      end
      if (w_ld_p0)     r_p0   <= w_prod;
      if (w_ld_p1)     r_p1   <= w_prod;
      if (w_ld_p2)     r_p2   <= w_prod;
      if (w_ld_full)   r_full <= w_full;
      if (w_ld_y_full) r_y    <= w_full;
      if (w_ld_y_red)  r_y    <= w_red;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.y         = r_y;

endmodule

// File: tb/tb_ka_gf2_mult_seq.sv
// Self-checking bench: directed and random operations on a 36-bit and a 7-bit instance.
module tb_ka_gf2_mult_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ka_gf2_mult_seq_if #(.WIDTH(36)) bus36 ();
  ka_gf2_mult_seq_if #(.WIDTH(7))  bus7 ();

  ka_gf2_mult_seq #(.WIDTH(36), .POLY(37'h10_0000_0801)) u_dut36 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus36)
  );

  ka_gf2_mult_seq #(.WIDTH(7), .POLY(8'h83)) u_dut7 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus7)
  );

  localparam logic [70:0] POLY36 = 71'h10_0000_0801;
  localparam logic [70:0] POLY7  = 71'h83;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Schoolbook carry-less product: coefficient of x^(i+j) flips for every a_i*b_j.
  function automatic logic [70:0] ref_clmul(input logic [35:0] x, input logic [35:0] z);
    logic [70:0] r;
    r = '0;
    for (int i = 0; i < 36; i++)
      for (int j = 0; j < 36; j++)
        if (x[i] && z[j]) r[i+j] = ~r[i+j];
    return r;
  endfunction

  // Sum of (x^i mod poly) over the set bits of p, with x^i mod poly built by repeated doubling.
  function automatic logic [70:0] ref_mod(input logic [70:0] p, input logic [70:0] poly, input int w);
    logic [70:0] t;
    logic [70:0] r;
    t = 71'd1;
    r = '0;
    for (int i = 0; i < 71; i++) begin
      if (p[i]) r = r ^ t;
      t = t << 1;
      if (t[w]) t = t ^ poly;
    end
    return r;
  endfunction

  task automatic op36(input logic [35:0] x, input logic [35:0] z, input logic red);
    logic [70:0] want;
    logic [70:0] yv;
    int lat;
    int first;
    logic seen;
    logic leaving;
    logic xfer;
    want = red ? ref_mod(ref_clmul(x, z), POLY36, 36) : ref_clmul(x, z);
    @(negedge clk);
    check("idle_ready36", 71'(bus36.in_ready), 71'd1);
    bus36.a = x; bus36.b = z; bus36.reduce = red; bus36.in_valid = 1'b1;
    @(posedge clk); #1;
    bus36.in_valid = 1'b0;
    bus36.a = 36'({$urandom(), $urandom()});
    bus36.b = 36'({$urandom(), $urandom()});
    bus36.reduce = ~red;
    lat = 0; first = 0; seen = 1'b0; leaving = 1'b0; xfer = 1'b0; yv = '0;
    while (!xfer && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (leaving) xfer = 1'b1;
      else begin
        if (bus36.out_valid && !seen) begin
          seen = 1'b1; first = lat; yv = 71'(bus36.y);
        end
        bus36.out_ready = 1'($urandom_range(0, 1));
        leaving = bus36.out_valid && bus36.out_ready;
      end
    end
    bus36.out_ready = 1'b0;
    check("lat36", 71'(first), red ? 71'd6 : 71'd5);
    check("y36", yv, want);
    check("post36", {69'd0, bus36.in_ready, bus36.out_valid}, 71'b10);
  endtask

  task automatic op7(input logic [6:0] x, input logic [6:0] z, input logic red);
    logic [70:0] want;
    logic [70:0] yv;
    int lat;
    int first;
    logic seen;
    logic leaving;
    logic xfer;
    want = red ? ref_mod(ref_clmul(36'(x), 36'(z)), POLY7, 7) : ref_clmul(36'(x), 36'(z));
    @(negedge clk);
    bus7.a = x; bus7.b = z; bus7.reduce = red; bus7.in_valid = 1'b1;
    @(posedge clk); #1;
    bus7.in_valid = 1'b0;
    bus7.a = 7'($urandom());
    bus7.b = 7'($urandom());
    bus7.reduce = ~red;
    lat = 0; first = 0; seen = 1'b0; leaving = 1'b0; xfer = 1'b0; yv = '0;
    while (!xfer && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (leaving) xfer = 1'b1;
      else begin
        if (bus7.out_valid && !seen) begin
          seen = 1'b1; first = lat; yv = 71'(bus7.y);
        end
        bus7.out_ready = 1'($urandom_range(0, 1));
        leaving = bus7.out_valid && bus7.out_ready;
      end
    end
    bus7.out_ready = 1'b0;
    check("lat7", 71'(first), red ? 71'd6 : 71'd5);
    check("y7", yv, want);
    check("post7", {69'd0, bus7.in_ready, bus7.out_valid}, 71'b10);
  endtask

  initial begin
    logic [70:0] want;
    int lat;
    logic quiet;

    bus36.in_valid = 1'b0; bus36.a = '0; bus36.b = '0; bus36.reduce = 1'b0; bus36.out_ready = 1'b0;
    bus7.in_valid  = 1'b0; bus7.a  = '0; bus7.b  = '0; bus7.reduce  = 1'b0; bus7.out_ready  = 1'b0;

    #12;
    check("rst_in_ready", 71'(bus36.in_ready), 71'd1);
    check("rst_out_valid", 71'(bus36.out_valid), 71'd0);
    check("rst_y", 71'(bus36.y), 71'd0);
    check("rst7_state", {69'd0, bus7.in_ready, bus7.out_valid}, 71'b10);
    @(negedge clk);
    rst_n = 1'b1;

    op36(36'h3, 36'h3, 1'b0);
    op36(36'h8_0000_0000, 36'h8_0000_0000, 1'b0);
    op36(36'h8_0000_0000, 36'h2, 1'b1);

    // Backpressure: hold the result for 10 cycles while a competing request is offered.
    want = ref_clmul(36'h5, 36'h7);
    @(negedge clk);
    bus36.a = 36'h5; bus36.b = 36'h7; bus36.reduce = 1'b0; bus36.in_valid = 1'b1;
    @(posedge clk); #1;
    bus36.in_valid = 1'b0;
    lat = 0;
    while (!bus36.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", 71'(lat), 71'd5);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_y", 71'(bus36.y), want);
      check("bp_hold_hs", {69'd0, bus36.in_ready, bus36.out_valid}, 71'b01);
      if (i == 3) begin
        bus36.a = 36'hF_FFFF_FFFF; bus36.b = 36'hF_FFFF_FFFF; bus36.in_valid = 1'b1;
      end else begin
        bus36.in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus36.in_valid = 1'b0;
    bus36.out_ready = 1'b1;
    @(posedge clk); #1;
    bus36.out_ready = 1'b0;
    check("bp_xfer", {69'd0, bus36.in_ready, bus36.out_valid}, 71'b10);
    quiet = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus36.out_valid || !bus36.in_ready) quiet = 1'b0;
    end
    check("bp_no_queue", 71'(quiet), 71'd1);

    // Reset while the third half-product is being formed.
    @(negedge clk);
    bus36.a = 36'h1_2345_6789; bus36.b = 36'hA_BCDE_F012; bus36.reduce = 1'b1; bus36.in_valid = 1'b1;
    @(posedge clk); #1;
    bus36.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 71'(bus36.in_ready), 71'd1);
    check("mid_rst_out_valid", 71'(bus36.out_valid), 71'd0);
    check("mid_rst_y", 71'(bus36.y), 71'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus36.out_valid || !bus36.in_ready) quiet = 1'b0;
    end
    check("abort_no_valid", 71'(quiet), 71'd1);
    op36(36'h1, 36'hF_FFFF_FFFF, 1'b0);

    for (int i = 0; i < 24; i++)
      op36(36'({$urandom(), $urandom()}), 36'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)));

    for (int i = 0; i < 1000; i++)
      op7(7'($urandom()), 7'($urandom()), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
